// File: rtl/uart_tx_merge_if.sv
// Source-side and pad-side signals of the serial merge, grouped so the merger
// and its driver share one connection.
interface uart_tx_merge_if #(
   parameter int CHANNELS = 3,
   parameter int OWN_W    = $clog2(CHANNELS)
);
   logic [CHANNELS-1:0] ch_in;
   logic [CHANNELS-1:0] ch_en;
   logic                mode;
   logic                tx;
   logic                busy;
   logic [OWN_W-1:0]    owner;
   logic                collision;

   modport master (
      output ch_in, ch_en, mode,
      input  tx, busy, owner, collision
   );

   modport slave (
      input  ch_in, ch_en, mode,
      output tx, busy, owner, collision
   );
endinterface

// File: rtl/uart_tx_merge.sv
// Merges several idle-high serial sources onto one TX line, either by legacy
// "last edge wins" or by locking the line to the first talker until it idles.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no owner; tx parked high (mode 1) or following edges (mode 0)
// S_OWNED | a channel owns the line; tx mirrors it until idle timeout
module uart_tx_merge #(
   parameter int CHANNELS    = 3,
   parameter int IDLE_CYCLES = 28000,
   parameter int OWN_W       = $clog2(CHANNELS),
   parameter int CNT_W       = $clog2(IDLE_CYCLES + 1)
) (
   input  logic            clk_sys,
   input  logic            reset_n,
   uart_tx_merge_if.slave  bus
);

   typedef enum logic {S_IDLE, S_OWNED} state_t;

   state_t              r_state;
   logic [CHANNELS-1:0] r_prev;
   logic                r_mode;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_tx;
   logic [OWN_W-1:0]    r_owner;
   logic                r_coll;

   state_t              w_state;
   logic [CNT_W-1:0]    w_cnt;
   logic                w_tx;
   logic [OWN_W-1:0]    w_owner;
   logic                w_coll;

   logic [CHANNELS-1:0] w_edge;
   logic [CHANNELS-1:0] w_fall;
   logic [CHANNELS-1:0] w_own_mask;
   logic [OWN_W-1:0]    w_hi_edge;
   logic [OWN_W-1:0]    w_lo_fall;
   logic                w_own_in;
   logic                w_own_en;
   logic                w_other_fall;

   assign w_edge       = (bus.ch_in ^ r_prev) & bus.ch_en;
   assign w_fall       = r_prev & ~bus.ch_in & bus.ch_en;
   assign w_own_mask   = CHANNELS'(1) << r_owner;
   assign w_own_in     = bus.ch_in[r_owner];
   assign w_own_en     = bus.ch_en[r_owner];
   assign w_other_fall = |(w_fall & ~w_own_mask);

   // Legacy merge favours the highest index; lock acquisition the lowest.
   always_comb begin
      w_hi_edge = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (w_edge[i]) w_hi_edge = OWN_W'(i);
      w_lo_fall = '0;
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (w_fall[i]) w_lo_fall = OWN_W'(i);
   end

   always_comb begin
      w_state = r_state;
      w_tx    = r_tx;
      w_owner = r_owner;
      w_cnt   = r_cnt;
      w_coll  = 1'b0;
      if (bus.mode != r_mode) begin
         w_state = S_IDLE;
         w_tx    = 1'b1;
         w_cnt   = '0;
      end else if (!bus.mode) begin
         w_state = S_IDLE;
         w_cnt   = '0;
         if (|w_edge) begin
            w_tx    = bus.ch_in[w_hi_edge];
            w_owner = w_hi_edge;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               w_tx  = 1'b1;
               w_cnt = '0;
               if (|w_fall) begin
                  w_state = S_OWNED;
                  w_owner = w_lo_fall;
                  w_tx    = 1'b0;
               end
            end
            S_OWNED: begin
               w_coll = w_other_fall;
               w_tx   = w_own_in;
               if (!w_own_en) begin
                  w_state = S_IDLE;
                  w_tx    = 1'b1;
                  w_cnt   = '0;
               end else if (!w_own_in) begin
                  w_cnt = '0;
               end else if (r_cnt == CNT_W'(IDLE_CYCLES - 1)) begin
                  w_state = S_IDLE;
                  w_tx    = 1'b1;
                  w_cnt   = '0;
               end else begin
                  w_cnt = r_cnt + 1'b1;
               end
            end
            default: w_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_prev  <= '1;
         r_mode  <= 1'b0;
         r_cnt   <= '0;
         r_tx    <= 1'b1;
         r_owner <= '0;
         r_coll  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_prev  <= bus.ch_in;
         r_mode  <= bus.mode;
         r_cnt   <= w_cnt;
         r_tx    <= w_tx;
         r_owner <= w_owner;
         r_coll  <= w_coll;
      end
   end

   assign bus.tx        = r_tx;
   assign bus.busy      = (r_state == S_OWNED);
   assign bus.owner     = r_owner;
   assign bus.collision = r_coll;

endmodule

// File: tb/tb_uart_tx_merge.sv
// Checks uart_tx_merge against a cycle-level behavioural model plus directed
// literal expectations, then random traffic with mode/enable churn.
module tb_uart_tx_merge;
   localparam int CH   = 3;
   localparam int IDLE = 8;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk   = 0;
   int   n_fail  = 0;

   uart_tx_merge_if #(.CHANNELS(CH)) bus ();

   uart_tx_merge #(.CHANNELS(CH), .IDLE_CYCLES(IDLE)) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk_sys = ~clk_sys;

   // Behavioural model: ownership as a flag, release by elapsed time since the
   // owner was last seen low.
   logic [CH-1:0] m_prev;
   logic          m_mode_q, m_locked, m_tx, m_coll;
   int            m_owner;
   longint        m_cyc, m_last_low;

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         m_prev = '1; m_mode_q = 1'b0; m_locked = 1'b0; m_tx = 1'b1;
         m_coll = 1'b0; m_owner = 0; m_cyc = 0; m_last_low = 0;
      end else begin
         logic [CH-1:0] edges, falls;
         int win;
         m_cyc++;
         edges  = (bus.ch_in ^ m_prev) & bus.ch_en;
         falls  = m_prev & ~bus.ch_in & bus.ch_en;
         m_coll = 1'b0;
         if (bus.mode != m_mode_q) begin
            m_locked = 1'b0; m_tx = 1'b1;
         end else if (!bus.mode) begin
            for (int i = 0; i < CH; i++)
               if (edges[i]) begin m_tx = bus.ch_in[i]; m_owner = i; end
         end else if (!m_locked) begin
            m_tx = 1'b1;
            win  = -1;
            for (int i = CH - 1; i >= 0; i--) if (falls[i]) win = i;
            if (win >= 0) begin
               m_owner = win; m_tx = 1'b0; m_locked = 1'b1; m_last_low = m_cyc;
            end
         end else begin
            for (int i = 0; i < CH; i++) if (i != m_owner && falls[i]) m_coll = 1'b1;
            if (!bus.ch_en[m_owner]) begin
               m_locked = 1'b0; m_tx = 1'b1;
            end else if (!bus.ch_in[m_owner]) begin
               m_tx = 1'b0; m_last_low = m_cyc;
            end else begin
               m_tx = 1'b1;
               if (m_cyc - m_last_low >= IDLE) m_locked = 1'b0;
            end
         end
         m_prev = bus.ch_in; m_mode_q = bus.mode;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_sys) begin
      chk("model_tx", int'(bus.tx), int'(m_tx));
      chk("model_busy", int'(bus.busy), int'(m_locked));
      chk("model_owner", int'(bus.owner), m_owner);
      chk("model_collision", int'(bus.collision), int'(m_coll));
   end

   task automatic tick();
      @(negedge clk_sys);
   endtask

   initial begin
      bus.ch_in = 3'b000; bus.ch_en = 3'b111; bus.mode = 1'b0;
      tick(); tick();
      chk("rst_tx", int'(bus.tx), 1);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_owner", int'(bus.owner), 0);
      chk("rst_coll", int'(bus.collision), 0);
      reset_n = 1'b1;
      tick();
      chk("post_rst_tx", int'(bus.tx), 0);
      chk("post_rst_owner", int'(bus.owner), 2);

      // legacy merge
      bus.ch_in = 3'b010; tick();
      chk("leg_rise1_tx", int'(bus.tx), 1); chk("leg_rise1_own", int'(bus.owner), 1);
      bus.ch_in = 3'b000; tick();
      chk("leg_fall1_tx", int'(bus.tx), 0); chk("leg_fall1_own", int'(bus.owner), 1);
      bus.ch_in = 3'b101; tick();
      chk("leg_rise02_tx", int'(bus.tx), 1); chk("leg_rise02_own", int'(bus.owner), 2);
      bus.ch_in = 3'b111; tick();
      bus.mode = 1'b1; tick();
      chk("modechg_tx", int'(bus.tx), 1); chk("modechg_busy", int'(bus.busy), 0);
      tick();

      // locked: ch2 acquires, toggles, then idles out
      bus.ch_in = 3'b011; tick();
      chk("acq2_busy", int'(bus.busy), 1); chk("acq2_owner", int'(bus.owner), 2);
      chk("acq2_tx", int'(bus.tx), 0);
      bus.ch_in = 3'b111; tick(); chk("mirror_hi", int'(bus.tx), 1);
      bus.ch_in = 3'b011; tick(); chk("mirror_lo", int'(bus.tx), 0);
      bus.ch_in = 3'b111;
      for (int k = 1; k < IDLE; k++) begin
         tick(); chk("busy_hold", int'(bus.busy), 1);
      end
      tick(); chk("busy_release", int'(bus.busy), 0);

      // collision while ch0 owns
      bus.ch_in = 3'b110; tick();
      chk("acq0_owner", int'(bus.owner), 0);
      bus.ch_in = 3'b100; tick();
      chk("coll_pulse", int'(bus.collision), 1); chk("coll_owner", int'(bus.owner), 0);
      chk("coll_tx", int'(bus.tx), 0);
      bus.ch_in = 3'b101; tick();
      chk("coll_clear", int'(bus.collision), 0); chk("coll_tx_follow", int'(bus.tx), 1);
      bus.ch_in = 3'b111;
      for (int k = 0; k < IDLE + 2; k++) tick();
      chk("idle_after_coll", int'(bus.busy), 0);

      // simultaneous falls, then disable owner
      bus.ch_in = 3'b001; tick();
      chk("simul_owner", int'(bus.owner), 1); chk("simul_busy", int'(bus.busy), 1);
      bus.ch_en = 3'b101; tick();
      chk("dis_tx", int'(bus.tx), 1); chk("dis_busy", int'(bus.busy), 0);
      bus.ch_en = 3'b111; bus.ch_in = 3'b111; tick();

      // mode 1->0 while owned with tx low
      bus.ch_in = 3'b011; tick();
      chk("acq2b_tx", int'(bus.tx), 0);
      bus.mode = 1'b0; tick();
      chk("m10_tx", int'(bus.tx), 1); chk("m10_busy", int'(bus.busy), 0);
      bus.ch_in = 3'b111; tick();
      chk("leg2_rise_own", int'(bus.owner), 2);
      bus.ch_in = 3'b011; tick();
      chk("leg2_fall_tx", int'(bus.tx), 0);
      bus.ch_in = 3'b001; tick();
      chk("leg2_ch1_own", int'(bus.owner), 1);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         logic [CH-1:0] v;
         v = bus.ch_in;
         for (int i = 0; i < CH; i++)
            if ($urandom_range(0, 5) == 0) v[i] = ~v[i];
         if ($urandom_range(0, 3) == 0) v = 3'b111;
         bus.ch_in = v;
         if ($urandom_range(0, 49) == 0) bus.ch_en = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 199) == 0) bus.mode = ~bus.mode;
         if (c == 2000) begin
            #2 reset_n = 1'b0;
            tick();
            #2 reset_n = 1'b1;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
